// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - branch-resolution queue feeding the predictor's two in-order update ports
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               pipeline flush: clears the queue, starts the training hold-off
//   in0_* / in1_*       resolution records from the branch units (in0 older than in1)
//   in_ready            at least two free slots this cycle
//   upd0_* / upd1_*     update records to the predictor (upd0 older than upd1)
//   occupancy           entries currently held
//   drop_cnt            saturating count of records rejected by a full queue

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 16
`endif

module bp_update_sched #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int DUAL_EN     = 1,
    parameter int GHR_BITS    = `BP_GHR_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in0_valid,
    input  logic [`INST_ADDR_WIDTH-1:0]     in0_pc,
    input  logic [`INST_ADDR_WIDTH-1:0]     in0_target,
    input  logic                            in0_taken,
    input  logic                            in0_is_call,
    input  logic                            in0_is_return,
    input  logic [GHR_BITS-1:0]             in0_hist,
    input  logic                            in1_valid,
    input  logic [`INST_ADDR_WIDTH-1:0]     in1_pc,
    input  logic [`INST_ADDR_WIDTH-1:0]     in1_target,
    input  logic                            in1_taken,
    input  logic                            in1_is_call,
    input  logic                            in1_is_return,
    input  logic [GHR_BITS-1:0]             in1_hist,
    output logic                            in_ready,
    output logic                            upd0_valid,
    output logic [`INST_ADDR_WIDTH-1:0]     upd0_pc,
    output logic                            upd0_taken,
    output logic [`INST_ADDR_WIDTH-1:0]     upd0_target,
    output logic [GHR_BITS-1:0]             upd0_hist,
    output logic                            upd0_is_call,
    output logic                            upd0_is_return,
    output logic                            upd1_valid,
    output logic [`INST_ADDR_WIDTH-1:0]     upd1_pc,
    output logic                            upd1_taken,
    output logic [`INST_ADDR_WIDTH-1:0]     upd1_target,
    output logic [GHR_BITS-1:0]             upd1_hist,
    output logic                            upd1_is_call,
    output logic                            upd1_is_return,
    output logic [$clog2(DEPTH):0]          occupancy,
    output logic [7:0]                      drop_cnt
);

    localparam int AW = `INST_ADDR_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef struct packed {
        logic [AW-1:0]       pc;
        logic [AW-1:0]       target;
        logic [GHR_BITS-1:0] hist;
        logic                taken;
        logic                is_call;
        logic                is_return;
    } entry_t;

    typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [OW-1:0]   occ_q;
    logic [7:0]      drop_q;
    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;

    entry_t          e0, e1, head0, head1, out0, out1;
    logic            v0, v1, ras0, ras1;
    logic [1:0]      n_valid, enq_n, deq_n;
    logic            drop_inc;
    logic [8:0]      drop_sum;
    logic [7:0]      drop_next;
    logic [PW-1:0]   wr_ptr1;

    assign e0 = '{pc: in0_pc, target: in0_target, hist: in0_hist, taken: in0_taken,
                  is_call: in0_is_call, is_return: in0_is_return};
    assign e1 = '{pc: in1_pc, target: in1_target, hist: in1_hist, taken: in1_taken,
                  is_call: in1_is_call, is_return: in1_is_return};

    // Free-space check uses start-of-cycle occupancy; same-cycle pops do not help.
    assign in_ready = (occ_q <= OW'(DEPTH - 2));
    assign n_valid  = {1'b0, in0_valid} + {1'b0, in1_valid};
    assign enq_n    = in_ready ? n_valid : 2'd0;
    assign drop_inc = !flush && !in_ready && (n_valid != 2'd0);
    assign drop_sum = {1'b0, drop_q} + {7'd0, n_valid};
    assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    assign wr_ptr1  = wr_ptr + PW'(1);

    // Issue side: the predictor's RAS accepts one call/return per cycle, so an
    // adjacent RAS pair at the head is split across two cycles.
    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PW'(1)];
    assign ras0  = head0.is_call | head0.is_return;
    assign ras1  = head1.is_call | head1.is_return;
    assign v0    = (state_q == S_RUN) && (occ_q != '0);
    assign v1    = (DUAL_EN != 0) && v0 && (occ_q >= OW'(2)) && !(ras0 && ras1);
    assign deq_n = {1'b0, v0} + {1'b0, v1};

    assign out0 = v0 ? head0 : '0;
    assign out1 = v1 ? head1 : '0;

    assign upd0_valid     = v0;
    assign upd0_pc        = out0.pc;
    assign upd0_taken     = out0.taken;
    assign upd0_target    = out0.target;
    assign upd0_hist      = out0.hist;
    assign upd0_is_call   = out0.is_call;
    assign upd0_is_return = out0.is_return;
    assign upd1_valid     = v1;
    assign upd1_pc        = out1.pc;
    assign upd1_taken     = out1.taken;
    assign upd1_target    = out1.target;
    assign upd1_hist      = out1.hist;
    assign upd1_is_call   = out1.is_call;
    assign upd1_is_return = out1.is_return;

    assign occupancy = occ_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (flush) begin
            if (HOLD_CYCLES > 0) begin
                state_d = S_HOLD;
                hold_d  = HW'(HOLD_CYCLES);
            end else begin
                state_d = S_RUN;
                hold_d  = '0;
            end
        end else if (state_q == S_HOLD) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            hold_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ_q  <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(enq_n);
                rd_ptr <= rd_ptr + PW'(deq_n);
                occ_q  <= occ_q + OW'(enq_n) - OW'(deq_n);
                if (drop_inc) begin
                    drop_q <= drop_next;
                end
            end
        end
    end

    // Compacted write: a lone in1 lands at wr_ptr, not wr_ptr+1.
    always_ff @(posedge clk) begin
        if (!rst && !flush && in_ready) begin
            if (in0_valid) begin
                mem[wr_ptr] <= e0;
            end
            if (in1_valid) begin
                mem[in0_valid ? wr_ptr1 : wr_ptr] <= e1;
            end
        end
    end

endmodule
